// File: rtl/sparc_exu_ccr_pkg.sv
// Shared types for the EXU CCR write-port arbiter.
//   ccr_t     : {xcc[3:0], icc[3:0]} condition-code byte
//   tid_t     : 2-bit hardware thread id
//   gnt_src_e : which source owns the CCR write port this cycle
package sparc_exu_ccr_pkg;

  typedef logic [7:0] ccr_t;
  typedef logic [1:0] tid_t;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_FIFO,
    GNT_W,
    GNT_DIV,
    GNT_TLU
  } gnt_src_e;

endpackage

// File: rtl/sparc_exu_ccr_skidfifo.sv
// Skid FIFO for W-stage CCR writes that lose arbitration.
// Holds DEPTH x {tid, data}; keeps a per-thread entry count so the
// arbiter can see which threads still have uncommitted writes queued.
//   clk, rst          : clock, synchronous active-high reset
//   i_push            : enqueue {i_push_tid, i_push_data}
//   i_pop             : dequeue head (ignored when empty)
//   o_head_tid/data   : current head entry
//   o_count           : occupancy
//   o_tid_pend[t]     : at least one entry belongs to thread t
module sparc_exu_ccr_skidfifo
  import sparc_exu_ccr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NTHR  = 4,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [1:0]      i_push_tid,
  input  logic [7:0]      i_push_data,
  input  logic            i_pop,
  output logic [1:0]      o_head_tid,
  output logic [7:0]      o_head_data,
  output logic [CW-1:0]   o_count,
  output logic [NTHR-1:0] o_tid_pend
);

  tid_t          r_tid_q  [DEPTH];
  ccr_t          r_data_q [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_tcnt   [NTHR];

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_cnt != '0);
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int unsigned t = 0; t < NTHR; t++) begin
        r_tcnt[t] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_tid_q[r_wptr]  <= i_push_tid;
        r_data_q[r_wptr] <= i_push_data;
        r_wptr           <= r_wptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
      for (int unsigned t = 0; t < NTHR; t++) begin
        r_tcnt[t] <= r_tcnt[t]
                   + CW'(w_do_push && (i_push_tid == tid_t'(t)))
                   - CW'(w_do_pop && (r_tid_q[r_rptr] == tid_t'(t)));
      end
    end
  end

  // Overflow is an upstream protocol violation; the write is dropped above.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && w_full && !w_do_pop));
    end
  end

  assign o_head_tid  = r_tid_q[r_rptr];
  assign o_head_data = r_data_q[r_rptr];
  assign o_count     = r_cnt;

  always_comb begin
    o_tid_pend = '0;
    for (int unsigned t = 0; t < NTHR; t++) begin
      o_tid_pend[t] = (r_tcnt[t] != '0);
    end
  end

endmodule

// File: rtl/sparc_exu_ccr_wrarb.sv
// CCR register-file write-port arbiter.
// Sources: W-stage ALU/WRCCR (cannot stall), divider setcc, TLU restore.
// W writes that lose arbitration are queued in a skid FIFO; once the FIFO
// is non-empty every W write goes through it so W order is preserved.
//   clk, rst                      : clock, synchronous active-high reset
//   w_vld, w_tid, w_data          : W-stage write
//   div_req, div_tid, div_data    : divider request (held until div_ack)
//   div_ack                       : divider write taken this cycle
//   tlu_req, tlu_tid, tlu_data    : TLU restore (held until tlu_ack)
//   tlu_ack                       : restore taken this cycle
//   ccr_we, ccr_wtid, ccr_wdata   : CCR file write port
//   ccr_pend                      : per-thread queued W writes
//   wrarb_stall                   : FIFO nearly full, stop setcc issue
module sparc_exu_ccr_wrarb #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 3,
  parameter int unsigned NTHR       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_vld,
  input  logic [1:0]      w_tid,
  input  logic [7:0]      w_data,
  input  logic            div_req,
  input  logic [1:0]      div_tid,
  input  logic [7:0]      div_data,
  output logic            div_ack,
  input  logic            tlu_req,
  input  logic [1:0]      tlu_tid,
  input  logic [7:0]      tlu_data,
  output logic            tlu_ack,
  output logic            ccr_we,
  output logic [1:0]      ccr_wtid,
  output logic [7:0]      ccr_wdata,
  output logic [NTHR-1:0] ccr_pend,
  output logic            wrarb_stall
);

  import sparc_exu_ccr_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  gnt_src_e      w_gnt;
  logic [SW-1:0] r_starve;
  logic [CW-1:0] w_cnt;
  logic [NTHR-1:0] w_pend;
  tid_t          w_head_tid;
  ccr_t          w_head_data;
  logic          w_fifo_ne;
  logic          w_div_blk;
  logic          w_tlu_blk;
  logic          w_starve;
  logic          w_push;
  logic          w_pop;

  sparc_exu_ccr_skidfifo #(
    .DEPTH (DEPTH),
    .NTHR  (NTHR)
  ) u_skidfifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_tid  (w_tid),
    .i_push_data (w_data),
    .i_pop       (w_pop),
    .o_head_tid  (w_head_tid),
    .o_head_data (w_head_data),
    .o_count     (w_cnt),
    .o_tid_pend  (w_pend)
  );

  assign w_fifo_ne = (w_cnt != '0);

  // Div/TLU must not overtake an older queued W write to the same thread.
  always_comb begin
    w_div_blk = 1'b0;
    w_tlu_blk = 1'b0;
    for (int unsigned t = 0; t < NTHR; t++) begin
      if (w_pend[t] && (div_tid == tid_t'(t))) w_div_blk = 1'b1;
      if (w_pend[t] && (tlu_tid == tid_t'(t))) w_tlu_blk = 1'b1;
    end
  end

  assign w_starve = div_req && !w_div_blk && (r_starve == SW'(STARVE_LIM));

  always_comb begin
    w_gnt = GNT_NONE;
    if (rst)                         w_gnt = GNT_NONE;
    else if (w_starve)               w_gnt = GNT_DIV;
    else if (w_fifo_ne)              w_gnt = GNT_FIFO;
    else if (w_vld)                  w_gnt = GNT_W;
    else if (div_req && !w_div_blk)  w_gnt = GNT_DIV;
    else if (tlu_req && !w_tlu_blk)  w_gnt = GNT_TLU;
  end

  assign w_push = !rst && w_vld && (w_gnt != GNT_W);
  assign w_pop  = (w_gnt == GNT_FIFO);

  always_comb begin
    ccr_we    = 1'b0;
    ccr_wtid  = '0;
    ccr_wdata = '0;
    div_ack   = 1'b0;
    tlu_ack   = 1'b0;
    case (w_gnt)
      GNT_FIFO: begin
        ccr_we    = 1'b1;
        ccr_wtid  = w_head_tid;
        ccr_wdata = w_head_data;
      end
      GNT_W: begin
        ccr_we    = 1'b1;
        ccr_wtid  = w_tid;
        ccr_wdata = w_data;
      end
      GNT_DIV: begin
        ccr_we    = 1'b1;
        ccr_wtid  = div_tid;
        ccr_wdata = div_data;
        div_ack   = 1'b1;
      end
      GNT_TLU: begin
        ccr_we    = 1'b1;
        ccr_wtid  = tlu_tid;
        ccr_wdata = tlu_data;
        tlu_ack   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !div_req || div_ack) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_LIM)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign ccr_pend    = w_pend;
  assign wrarb_stall = (w_cnt >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_sparc_exu_ccr_wrarb.sv
// Directed bench for sparc_exu_ccr_wrarb (DEPTH=4, STARVE_LIM=3, NTHR=4).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_sparc_exu_ccr_wrarb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_vld = 1'b0;
  logic [1:0] w_tid = '0;
  logic [7:0] w_data = '0;
  logic       div_req = 1'b0;
  logic [1:0] div_tid = '0;
  logic [7:0] div_data = '0;
  logic       div_ack;
  logic       tlu_req = 1'b0;
  logic [1:0] tlu_tid = '0;
  logic [7:0] tlu_data = '0;
  logic       tlu_ack;
  logic       ccr_we;
  logic [1:0] ccr_wtid;
  logic [7:0] ccr_wdata;
  logic [3:0] ccr_pend;
  logic       wrarb_stall;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sparc_exu_ccr_wrarb #(
    .DEPTH      (4),
    .STARVE_LIM (3),
    .NTHR       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_vld       (w_vld),
    .w_tid       (w_tid),
    .w_data      (w_data),
    .div_req     (div_req),
    .div_tid     (div_tid),
    .div_data    (div_data),
    .div_ack     (div_ack),
    .tlu_req     (tlu_req),
    .tlu_tid     (tlu_tid),
    .tlu_data    (tlu_data),
    .tlu_ack     (tlu_ack),
    .ccr_we      (ccr_we),
    .ccr_wtid    (ccr_wtid),
    .ccr_wdata   (ccr_wdata),
    .ccr_pend    (ccr_pend),
    .wrarb_stall (wrarb_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic vec(input string tag, input logic r,
                     input logic wv, input logic [1:0] wt, input logic [7:0] wd,
                     input logic dv, input logic [1:0] dt, input logic [7:0] dd,
                     input logic tv, input logic [1:0] tt, input logic [7:0] td,
                     input logic e_we, input logic [1:0] e_tid, input logic [7:0] e_wd,
                     input logic e_dack, input logic e_tack,
                     input logic [3:0] e_pend, input logic e_stall);
    @(negedge clk);
    rst = r;
    w_vld = wv;    w_tid = wt;    w_data = wd;
    div_req = dv;  div_tid = dt;  div_data = dd;
    tlu_req = tv;  tlu_tid = tt;  tlu_data = td;
    #1;
    check({tag, ".we"},    ccr_we,      e_we);
    check({tag, ".wtid"},  ccr_wtid,    e_tid);
    check({tag, ".wdata"}, ccr_wdata,   e_wd);
    check({tag, ".dack"},  div_ack,     e_dack);
    check({tag, ".tack"},  tlu_ack,     e_tack);
    check({tag, ".pend"},  ccr_pend,    e_pend);
    check({tag, ".stall"}, wrarb_stall, e_stall);
  endtask

  task automatic idle(input string tag, input logic [3:0] e_pend);
    vec(tag, 1'b0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, e_pend, 0);
  endtask

  // Full/stall scenario: W tid0 every cycle 0..12, div tid3 re-requested
  // after each ack (cycles 0..11), starvation grants at 3, 7, 11.
  logic [7:0]  f_wd [17] = '{8'h60, 8'h61, 8'h62, 8'hD0, 8'h63, 8'h64, 8'h65, 8'hD1,
                             8'h66, 8'h67, 8'h68, 8'hD2, 8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h00};
  logic [16:0] f_we    = 17'h0FFFF;
  logic [16:0] f_dack  = 17'h00888;
  logic [16:0] f_pend  = 17'h0FFF0;
  logic [16:0] f_stall = 17'h03000;

  // Reset-mid-drain prefix: same pattern, base 8'h80, two entries queued after cycle 7.
  logic [7:0]  r_wd [8] = '{8'h80, 8'h81, 8'h82, 8'hD0, 8'h83, 8'h84, 8'h85, 8'hD1};
  logic [7:0]  r_pnd    = 8'hF0;

  initial begin
    // Reset with all requesters active: nothing may be written.
    vec("rst0", 1, 1, 1, 8'h11, 1, 0, 8'h22, 1, 2, 8'h33, 0, 0, 8'h00, 0, 0, 4'h0, 0);
    vec("rst1", 1, 1, 1, 8'h11, 1, 0, 8'h22, 1, 2, 8'h33, 0, 0, 8'h00, 0, 0, 4'h0, 0);
    idle("post_rst", 4'h0);

    // Lone W write goes straight to the file.
    vec("loneW", 0, 1, 2, 8'hA5, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2, 8'hA5, 0, 0, 4'h0, 0);
    idle("loneW_after", 4'h0);

    // W beats div; div granted the next cycle.
    vec("coll0", 0, 1, 1, 8'h11, 1, 0, 8'h22, 0, 0, 8'h00, 1, 1, 8'h11, 0, 0, 4'h0, 0);
    vec("coll1", 0, 0, 0, 8'h00, 1, 0, 8'h22, 0, 0, 8'h00, 1, 0, 8'h22, 1, 0, 4'h0, 0);
    idle("coll2", 4'h0);

    // Starvation: div wins on its 4th waiting cycle, W queued then drained in order.
    vec("stv0", 0, 1, 0, 8'h40, 1, 3, 8'h33, 0, 0, 8'h00, 1, 0, 8'h40, 0, 0, 4'h0, 0);
    vec("stv1", 0, 1, 0, 8'h41, 1, 3, 8'h33, 0, 0, 8'h00, 1, 0, 8'h41, 0, 0, 4'h0, 0);
    vec("stv2", 0, 1, 0, 8'h42, 1, 3, 8'h33, 0, 0, 8'h00, 1, 0, 8'h42, 0, 0, 4'h0, 0);
    vec("stv3", 0, 1, 0, 8'h43, 1, 3, 8'h33, 0, 0, 8'h00, 1, 3, 8'h33, 1, 0, 4'h0, 0);
    vec("stv4", 0, 1, 0, 8'h44, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h43, 0, 0, 4'h1, 0);
    vec("stv5", 0, 1, 0, 8'h45, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h44, 0, 0, 4'h1, 0);
    vec("stv6", 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h45, 0, 0, 4'h1, 0);
    idle("stv7", 4'h0);

    // TLU restore to tid0 waits behind a queued tid0 W write.
    vec("tlu0", 0, 1, 0, 8'h50, 1, 1, 8'hD1, 0, 0, 8'h00, 1, 0, 8'h50, 0, 0, 4'h0, 0);
    vec("tlu1", 0, 1, 0, 8'h51, 1, 1, 8'hD1, 0, 0, 8'h00, 1, 0, 8'h51, 0, 0, 4'h0, 0);
    vec("tlu2", 0, 1, 0, 8'h52, 1, 1, 8'hD1, 0, 0, 8'h00, 1, 0, 8'h52, 0, 0, 4'h0, 0);
    vec("tlu3", 0, 1, 0, 8'h53, 1, 1, 8'hD1, 1, 0, 8'h7E, 1, 1, 8'hD1, 1, 0, 4'h0, 0);
    vec("tlu4", 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h7E, 1, 0, 8'h53, 0, 0, 4'h1, 0);
    vec("tlu5", 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 8'h7E, 1, 0, 8'h7E, 0, 1, 4'h0, 0);
    idle("tlu6", 4'h0);

    // Starved div to tid0 is held off while tid0 W writes remain queued.
    vec("ord0", 0, 1, 0, 8'h70, 1, 1, 8'hE1, 0, 0, 8'h00, 1, 0, 8'h70, 0, 0, 4'h0, 0);
    vec("ord1", 0, 1, 0, 8'h71, 1, 1, 8'hE1, 0, 0, 8'h00, 1, 0, 8'h71, 0, 0, 4'h0, 0);
    vec("ord2", 0, 1, 0, 8'h72, 1, 1, 8'hE1, 0, 0, 8'h00, 1, 0, 8'h72, 0, 0, 4'h0, 0);
    vec("ord3", 0, 1, 0, 8'h73, 1, 1, 8'hE1, 0, 0, 8'h00, 1, 1, 8'hE1, 1, 0, 4'h0, 0);
    vec("ord4", 0, 1, 0, 8'h74, 1, 0, 8'hE0, 0, 0, 8'h00, 1, 0, 8'h73, 0, 0, 4'h1, 0);
    vec("ord5", 0, 1, 0, 8'h75, 1, 0, 8'hE0, 0, 0, 8'h00, 1, 0, 8'h74, 0, 0, 4'h1, 0);
    vec("ord6", 0, 1, 0, 8'h76, 1, 0, 8'hE0, 0, 0, 8'h00, 1, 0, 8'h75, 0, 0, 4'h1, 0);
    vec("ord7", 0, 1, 0, 8'h77, 1, 0, 8'hE0, 0, 0, 8'h00, 1, 0, 8'h76, 0, 0, 4'h1, 0);
    vec("ord8", 0, 0, 0, 8'h00, 1, 0, 8'hE0, 0, 0, 8'h00, 1, 0, 8'h77, 0, 0, 4'h1, 0);
    vec("ord9", 0, 0, 0, 8'h00, 1, 0, 8'hE0, 0, 0, 8'h00, 1, 0, 8'hE0, 1, 0, 4'h0, 0);
    idle("ord10", 4'h0);

    // Fill to 3 entries via repeated starvation, check stall and drain order.
    for (int i = 0; i < 17; i++) begin
      vec($sformatf("full%0d", i), 0,
          (i <= 12), 2'd0, 8'h60 + 8'(i),
          (i <= 11), 2'd3, 8'hD0 + 8'(i / 4),
          0, 0, 8'h00,
          f_we[i], f_dack[i] ? 2'd3 : 2'd0, f_wd[i],
          f_dack[i], 0, {3'b000, f_pend[i]}, f_stall[i]);
    end

    // Reset while two entries are queued: nothing stale is written afterwards.
    for (int i = 0; i < 8; i++) begin
      vec($sformatf("rmd%0d", i), 0,
          1, 2'd0, 8'h80 + 8'(i),
          1, 2'd3, 8'hD0 + 8'(i / 4),
          0, 0, 8'h00,
          1, (i == 3 || i == 7) ? 2'd3 : 2'd0, r_wd[i],
          (i == 3 || i == 7), 0, {3'b000, r_pnd[i]}, 0);
    end
    vec("rmd_rst", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 4'h1, 0);
    idle("rmd_post0", 4'h0);
    idle("rmd_post1", 4'h0);
    vec("rmd_newW", 0, 1, 2, 8'h9A, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2, 8'h9A, 0, 0, 4'h0, 0);
    idle("rmd_end", 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
